// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: memory ALU opcodes, FSM state encodings
// and opcode classification helpers.
package lsu_pkg;

    localparam logic [5:0] ALU_ADD = 6'h00;
    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h22;
    localparam logic [5:0] ALU_LBU = 6'h23;
    localparam logic [5:0] ALU_LHU = 6'h24;
    localparam logic [5:0] ALU_SB  = 6'h28;
    localparam logic [5:0] ALU_SH  = 6'h29;
    localparam logic [5:0] ALU_SW  = 6'h2A;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_store(input logic [5:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    function automatic logic is_load(input logic [5:0] code);
        return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
               (code == ALU_LBU) || (code == ALU_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] lo);
        logic half;
        logic word;
        half = (code == ALU_LH) || (code == ALU_LHU) || (code == ALU_SH);
        word = (code == ALU_LW) || (code == ALU_SW);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication/strobes and load lane select with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [5:0]  alu_code,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        lane_byte = shifted[7:0];
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wdata     = store_data;
        wstrb     = 4'b0000;
        load_data = rdata;
        case (alu_code)
            ALU_SB: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            ALU_SH: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            ALU_SW:  wstrb = 4'b1111;
            ALU_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
            ALU_LBU: load_data = {24'h000000, lane_byte};
            ALU_LH:  load_data = {{16{lane_half[15]}}, lane_half};
            ALU_LHU: load_data = {16'h0000, lane_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one word-aligned req/ack bus transaction per access with timeout.
// Optional alignment trap when LSU_MISALIGN_TRAP_EN is defined (adds the misalign port).
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [5:0]  alu_code,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        bus_err
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    lsu_state_t  state, state_nxt;
    logic [5:0]  code_q;
    logic [31:0] addr_q;
    logic [31:0] sd_q;
    logic [31:0] cnt_q;
    logic [31:0] load_q;
    logic        bus_err_q;
    logic        busy_q;
    logic        accept, ack_hit, tmo_hit, trap;
    logic [31:0] al_wdata, al_ldata;
    logic [3:0]  al_wstrb;
    logic        in_req;

    lsu_align u_align (
        .alu_code   (code_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (sd_q),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_ldata)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        trap      = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (start && (is_load(alu_code) || is_store(alu_code))) begin
                    accept = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    trap = is_misaligned(alu_code, addr[1:0]);
`endif
                    state_nxt = trap ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = LSU_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES))) begin
                    tmo_hit   = 1'b1;
                    state_nxt = LSU_DONE;
                end
            end
            LSU_DONE: state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= LSU_IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != LSU_IDLE);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            code_q    <= ALU_ADD;
            addr_q    <= '0;
            sd_q      <= '0;
            cnt_q     <= '0;
            load_q    <= '0;
            bus_err_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                code_q <= alu_code;
                addr_q <= addr;
                sd_q   <= store_data;
                cnt_q  <= '0;
            end else if ((state == LSU_REQ) && !mem_ack && (TIMEOUT_CYCLES != 0)) begin
                cnt_q <= cnt_q + 32'd1;
            end
            // Result flags are written only on completion so they hold across IDLE.
            if (ack_hit || tmo_hit || trap) begin
                load_q    <= ack_hit ? al_ldata : 32'h0;
                bus_err_q <= tmo_hit;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign  <= trap;
`endif
            end
        end
    end

    assign in_req    = (state == LSU_REQ);
    assign mem_req   = in_req;
    assign mem_we    = in_req && is_store(code_q);
    assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata = (in_req && is_store(code_q)) ? al_wdata : 32'h0;
    assign mem_wstrb = in_req ? al_wstrb : 4'b0000;
    assign busy      = busy_q;
    assign done      = (state == LSU_DONE);
    assign load_data = load_q;
    assign bus_err   = bus_err_q;

endmodule
